// File: rtl/edc_pkg.sv
// Shared definitions for the ECC memory scrubber.
//   - edc_state_e   : scrubber FSM state encoding
//   - EDC_LINE_BYTES: bytes per scrubbed line (address stride)
//   - EDC_WB_DWIDTH : Wishbone data width
//   - EDC_WB_SWIDTH : Wishbone byte-select width
//   - EDC_CNT_WIDTH : width of the inter-line interval counter
package edc_pkg;

  localparam int EDC_LINE_BYTES = 16;
  localparam int EDC_WB_DWIDTH  = 128;
  localparam int EDC_WB_SWIDTH  = 16;
  localparam int EDC_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_WRITE,
    ST_NEXT
  } edc_state_e;

endpackage

// File: rtl/edc_scrub_timer.sv
// Loadable down-counter used to space line scrubs apart.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   load         : load count with load_val (has priority over dec)
//   dec          : decrement by one, holding at zero
//   load_val     : value loaded on load
//   zero         : count is zero
module edc_scrub_timer
  import edc_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     load,
  input  logic                     dec,
  input  logic [EDC_CNT_WIDTH-1:0] load_val,
  output logic                     zero
);

  logic [EDC_CNT_WIDTH-1:0] count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edc_scrubber.sv
// Background ECC memory scrubber: a Wishbone initiator that walks memory one
// line at a time, doing a locked read-modify-write so corrected read data is
// written back with fresh check bits.
// Optional feature macro: EDC_SCRUBBER_STATS_EN (error count / address regs).
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_enable          : scrubbing permitted
//   o_wb_*/i_wb_*     : 128-bit Wishbone initiator port
//   o_busy            : bus cycle in progress (mirrors o_wb_cyc)
//   o_pass_done       : one-cycle pulse after the last line is handled
//   o_uncorrectable   : one-cycle pulse after a read returned err
//   o_err_count       : saturating uncorrectable-line count (stats build)
//   o_err_adr         : most recent uncorrectable line (stats build)
module edc_scrubber
  import edc_pkg::*;
#(
  parameter logic [31:0] ADDR_START = 32'h0000_0000,
  parameter logic [31:0] ADDR_END   = 32'h07FF_FFF0,
  parameter int unsigned INTERVAL   = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  output logic [31:0]              o_wb_adr,
  output logic [EDC_WB_SWIDTH-1:0] o_wb_sel,
  output logic                     o_wb_we,
  output logic [EDC_WB_DWIDTH-1:0] o_wb_dat,
  input  logic [EDC_WB_DWIDTH-1:0] i_wb_dat,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  output logic                     o_busy,
  output logic                     o_pass_done,
  output logic                     o_uncorrectable,
  output logic [15:0]              o_err_count,
  output logic [31:0]              o_err_adr
);

  localparam logic [EDC_CNT_WIDTH-1:0] INTERVAL_CNT = EDC_CNT_WIDTH'(INTERVAL);

  edc_state_e               state, state_nxt;
  logic [31:0]              adr_q;
  logic [EDC_WB_DWIDTH-1:0] buf_q;
  logic                     pass_q;
  logic                     unc_q;
  logic                     tmr_load;
  logic                     tmr_dec;
  logic                     tmr_zero;
  logic                     last_line;

  assign last_line = (adr_q == ADDR_END);

  edc_scrub_timer u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (INTERVAL_CNT),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_enable) state_nxt = ST_WAIT;
      ST_WAIT:  if (tmr_zero) state_nxt = i_enable ? ST_READ : ST_IDLE;
      // err wins over ack: an uncorrectable line is never written back
      ST_READ:  if (i_wb_err) state_nxt = ST_NEXT;
                else if (i_wb_ack) state_nxt = ST_WRITE;
      ST_WRITE: if (i_wb_ack || i_wb_err) state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = ST_WAIT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; cyc stays high across
  // READ->WRITE so the arbiter keeps the bus locked for the whole RMW.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state)
      ST_IDLE:  tmr_load = i_enable;
      ST_WAIT:  tmr_dec  = 1'b1;
      ST_READ:  begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
      end
      ST_WRITE: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b1;
      end
      ST_NEXT:  tmr_load = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adr_q  <= ADDR_START;
      buf_q  <= '0;
      pass_q <= 1'b0;
      unc_q  <= 1'b0;
    end else begin
      pass_q <= (state == ST_NEXT) && last_line;
      unc_q  <= (state == ST_READ) && i_wb_err;
      if ((state == ST_READ) && i_wb_ack && !i_wb_err) buf_q <= i_wb_dat;
      if (state == ST_NEXT) adr_q <= last_line ? ADDR_START : adr_q + 32'(EDC_LINE_BYTES);
    end
  end

`ifdef EDC_SCRUBBER_STATS_EN
  logic [15:0] err_count_q;
  logic [31:0] err_adr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_count_q <= '0;
      err_adr_q   <= '0;
    end else if ((state == ST_READ) && i_wb_err) begin
      err_adr_q <= adr_q;
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 1'b1;
    end
  end

  assign o_err_count = err_count_q;
  assign o_err_adr   = err_adr_q;
`else
  assign o_err_count = '0;
  assign o_err_adr   = '0;
`endif

  assign o_wb_adr        = adr_q;
  assign o_wb_sel        = o_wb_cyc ? '1 : '0;
  assign o_wb_dat        = buf_q;
  assign o_busy          = o_wb_cyc;
  assign o_pass_done     = pass_q;
  assign o_uncorrectable = unc_q;

endmodule
